// File: rtl/audio_pkg.sv
// Shared constants, sample type and conditioner FSM states for the ADC audio path.
package audio_pkg;

  localparam int ADC_MIDSCALE = 2048;
  localparam int S16_MAX      = 32767;
  localparam int S16_MIN      = -32768;

  typedef logic signed [15:0] sample16_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DCUPD = 2'd1,
    ST_SAT   = 2'd2
  } cond_state_t;

endpackage

// File: rtl/audio_dc_blocker.sv
// Leaky-integrator DC estimate with offset subtraction and signed 16-bit saturation.
module audio_dc_blocker
  import audio_pkg::*;
#(
  parameter int unsigned DC_SHIFT  = 10,
  parameter int unsigned ENABLE_DC = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        upd,
  input  logic        sat,
  input  logic [15:0] avg,
  output logic [15:0] y_c,
  output logic        clip_c
);

  localparam int unsigned DCW = 24;

  logic signed [DCW-1:0] dc_acc;
  logic        [15:0]    dc_q;
  logic signed [DCW:0]   err_c;
  logic        [15:0]    dc_sub;
  logic signed [16:0]    y_wide;
  logic                  ovf;

  assign err_c = $signed({avg[15], avg, 8'b0}) - $signed({dc_acc[DCW-1], dc_acc});

  // dc_q snapshots the estimate before this block's update so SAT subtracts the prior value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_acc <= '0;
      dc_q   <= '0;
    end else if (upd) begin
      dc_q   <= dc_acc[DCW-1:8];
      dc_acc <= dc_acc + DCW'(err_c >>> DC_SHIFT);
    end
  end

  always_comb begin
    dc_sub = (ENABLE_DC != 0) ? dc_q : 16'd0;
    y_wide = $signed({avg[15], avg}) - $signed({dc_sub[15], dc_sub});
    y_c    = y_wide[15:0];
    ovf    = 1'b0;
    if (y_wide[16] != y_wide[15]) begin
      ovf = 1'b1;
      y_c = y_wide[16] ? 16'(S16_MIN) : 16'(S16_MAX);
    end
    clip_c = sat & ovf;
  end

endmodule

// File: rtl/audio_adc_conditioner.sv
// ADC sample conditioner: edge-detect, boxcar decimation, DC removal, saturation, watchdog mute.
module audio_adc_conditioner
  import audio_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned DC_SHIFT   = 10,
  parameter int unsigned ENABLE_DC  = 1,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [11:0] audio_sample,
  input  logic        mute,
  output logic [15:0] sample_out,
  output logic        out_valid,
  output logic        clip,
  output logic        adc_fault
);

  localparam int unsigned AW = 12 + DECIM_LOG2;
  localparam int unsigned CW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
  localparam int unsigned WW = 20;
  localparam logic [CW-1:0] COUNT_LAST = CW'((1 << DECIM_LOG2) - 1);
  localparam logic [WW-1:0] WD_ARM     = WW'(TIMEOUT - 2);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

  cond_state_t        state;
  logic               sv_q;
  logic signed [AW-1:0] acc;
  logic [CW-1:0]      count;
  logic [WW-1:0]      wd;
  sample16_t          avg_q;

  logic               accept_c;
  logic               wrap_c;
  logic               expire_c;
  logic signed [11:0] x_c;
  logic signed [AW-1:0] acc_sum_c;
  sample16_t          avg16_c;
  logic [15:0]        y_c;
  logic               clip_c;
  logic               upd_c;
  logic               sat_c;

  assign accept_c  = sample_valid & ~sv_q;
  assign x_c       = $signed(audio_sample - 12'(ADC_MIDSCALE));
  assign acc_sum_c = acc + AW'(x_c);
  assign avg16_c   = {acc_sum_c[AW-1:DECIM_LOG2], 4'b0000};
  assign wrap_c    = accept_c && (count == COUNT_LAST);
  // an accept in the expiry cycle keeps the watchdog alive
  assign expire_c  = !accept_c && (wd == WD_ARM);
  assign upd_c     = (state == ST_DCUPD);
  assign sat_c     = (state == ST_SAT);

  audio_dc_blocker #(
    .DC_SHIFT (DC_SHIFT),
    .ENABLE_DC(ENABLE_DC)
  ) u_dc_blocker (
    .clk    (clk),
    .reset_n(reset_n),
    .upd    (upd_c),
    .sat    (sat_c),
    .avg    (avg_q),
    .y_c    (y_c),
    .clip_c (clip_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sv_q       <= 1'b0;
      acc        <= '0;
      count      <= '0;
      wd         <= '0;
      avg_q      <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      clip       <= 1'b0;
      adc_fault  <= 1'b0;
    end else begin
      sv_q      <= sample_valid;
      out_valid <= 1'b0;
      clip      <= 1'b0;

      // accumulation runs independently of the FSM so no accept is dropped
      if (expire_c) begin
        acc       <= '0;
        count     <= '0;
        adc_fault <= 1'b1;
      end else if (accept_c) begin
        adc_fault <= 1'b0;
        if (wrap_c) begin
          acc   <= '0;
          count <= '0;
          avg_q <= avg16_c;
        end else begin
          acc   <= acc_sum_c;
          count <= count + CW'(1);
        end
      end

      if (accept_c) begin
        wd <= '0;
      end else if (wd != WD_LAST) begin
        wd <= wd + WW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (wrap_c) state <= ST_DCUPD;
        end
        ST_DCUPD: begin
          state <= ST_SAT;
        end
        ST_SAT: begin
          out_valid  <= 1'b1;
          clip       <= clip_c;
          sample_out <= (mute | adc_fault) ? 16'd0 : y_c;
          state      <= wrap_c ? ST_DCUPD : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (expire_c) sample_out <= '0;
    end
  end

endmodule

// File: tb/tb_audio_adc_conditioner.sv
// Randomized self-checking bench for audio_adc_conditioner against a behavioural model.
module tb_audio_adc_conditioner;

  localparam int D   = 2;
  localparam int DCS = 4;
  localparam int END = 1;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] audio_sample = 12'd0;
  logic        mute = 1'b0;
  logic [15:0] sample_out;
  logic        out_valid;
  logic        clip;
  logic        adc_fault;

  int total = 0;
  int bad   = 0;
  bit mute_req = 1'b0;

  always #5 clk = ~clk;

  audio_adc_conditioner #(
    .DECIM_LOG2(D),
    .DC_SHIFT  (DCS),
    .ENABLE_DC (END),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .audio_sample(audio_sample),
    .mute        (mute),
    .sample_out  (sample_out),
    .out_valid   (out_valid),
    .clip        (clip),
    .adc_fault   (adc_fault)
  );

  // Behavioural model state
  typedef struct {
    int due;
    int val;
    bit clp;
  } pend_t;

  int     ncyc = 0;
  bit     m_prev = 0;
  int     m_blk[$];
  longint m_dc = 0;
  int     m_idle = 0;
  bit     m_fault = 0;
  int     m_out = 0;
  bit     m_ov = 0;
  bit     m_clip = 0;
  pend_t  m_pend[$];
  int     last_acc_edge = 0;
  int     last_wrap_edge = 0;
  int     fault_edge = 0;
  int     ov_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs appear two edges after the accept edge that completes a block
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_prev = 0; m_blk.delete(); m_dc = 0; m_idle = 0; m_fault = 0;
        m_out = 0; m_ov = 0; m_clip = 0; m_pend.delete();
        continue;
      end
      begin
        bit acc;
        bit expire;
        ncyc++;
        acc    = sample_valid && !m_prev;
        m_prev = sample_valid;
        m_ov   = 0;
        m_clip = 0;
        expire = 0;
        if (!acc && m_idle < TO - 1) begin
          m_idle++;
          if (m_idle == TO - 1) expire = 1;
        end
        if (m_pend.size() > 0 && m_pend[0].due == ncyc) begin
          pend_t p;
          p = m_pend.pop_front();
          m_ov   = 1;
          m_clip = p.clp;
          m_out  = (mute || m_fault) ? 0 : p.val;
        end
        if (expire) begin
          m_fault = 1;
          m_out = 0;
          m_blk.delete();
          fault_edge = ncyc;
        end
        if (acc) begin
          m_fault = 0;
          m_idle = 0;
          last_acc_edge = ncyc;
          m_blk.push_back(int'(audio_sample) - 2048);
          if (m_blk.size() == (1 << D)) begin
            int sum, avg, dc, y;
            pend_t p;
            sum = 0;
            foreach (m_blk[i]) sum += m_blk[i];
            avg = (sum >>> D) * 16;
            dc  = int'(m_dc >>> 8);
            y   = avg - ((END != 0) ? dc : 0);
            p.clp = 0;
            p.val = y;
            if (y > 32767) begin p.val = 32767; p.clp = 1; end
            else if (y < -32768) begin p.val = -32768; p.clp = 1; end
            p.due = ncyc + 2;
            m_pend.push_back(p);
            m_dc = m_dc + (((longint'(avg) * 256) - m_dc) >>> DCS);
            last_wrap_edge = ncyc;
            m_blk.delete();
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("clip", int'(clip), int'(m_clip));
      chk("adc_fault", int'(adc_fault), int'(m_fault));
      chk("sample_out", int'($signed(sample_out)), m_out);
      if (out_valid) ov_count++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic pulse(input int val, input int hold);
    @(posedge clk);
    #2;
    mute = mute_req;
    sample_valid = 1'b1;
    audio_sample = 12'(val);
    repeat (hold) @(posedge clk);
    #2;
    sample_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic block4(input int val);
    for (int i = 0; i < 4; i++) pulse(val, 1);
  endtask

  task automatic wait_ov(input string name, output bit seen);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    bit seen;
    int ov0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_sample_out", int'(sample_out), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_clip", int'(clip), 0);
    chk("reset_adc_fault", int'(adc_fault), 0);

    // Basic block and latency
    block4(2148);
    wait_ov("ov_2148", seen);
    chk("val_2148", int'($signed(sample_out)), 1600);
    chk("clip_2148", int'(clip), 0);
    chk("latency", ncyc - last_wrap_edge, 2);

    // Full-scale extremes from a clean DC state
    do_reset();
    block4(0);
    wait_ov("ov_zero", seen);
    chk("val_zero", int'($signed(sample_out)), -32768);
    chk("clip_zero", int'(clip), 0);
    do_reset();
    block4(4095);
    wait_ov("ov_max", seen);
    chk("val_max", int'($signed(sample_out)), 32752);
    chk("clip_max", int'(clip), 0);

    // Held valid level counts once per rising edge
    do_reset();
    ov0 = ov_count;
    for (int i = 0; i < 4; i++) pulse(2148, 10);
    repeat (10) @(negedge clk);
    chk("held_ov_count", ov_count - ov0, 1);

    // Watchdog expiry and recovery
    repeat (130) @(posedge clk);
    @(negedge clk);
    chk("fault_set", int'(adc_fault), 1);
    chk("fault_out_zero", int'(sample_out), 0);
    chk("fault_edge", fault_edge - last_acc_edge, 99);
    ov0 = ov_count;
    pulse(2148, 1);
    @(negedge clk);
    chk("fault_cleared", int'(adc_fault), 0);
    pulse(2148, 1);
    pulse(2148, 1);
    repeat (6) @(negedge clk);
    chk("fault_no_early_ov", ov_count - ov0, 0);
    pulse(2148, 1);
    wait_ov("fault_recover_ov", seen);

    // Mute keeps cadence but zeros value
    mute_req = 1'b1;
    block4(3000);
    wait_ov("mute_ov", seen);
    chk("mute_val", int'(sample_out), 0);
    mute_req = 1'b0;
    block4(2500);
    wait_ov("unmute_ov", seen);

    // Reset asserted during the DC update cycle
    for (int i = 0; i < 3; i++) pulse(2148, 1);
    @(posedge clk);
    #2 sample_valid = 1'b1;
    @(posedge clk);
    #2 sample_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_out", int'(sample_out), 0);
    chk("midreset_ov", int'(out_valid), 0);
    chk("midreset_fault", int'(adc_fault), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    ov0 = ov_count;
    repeat (8) @(negedge clk);
    chk("midreset_no_ov", ov_count - ov0, 0);
    for (int i = 0; i < 3; i++) pulse(2148, 1);
    repeat (4) @(negedge clk);
    chk("midreset_fresh_block", ov_count - ov0, 0);
    pulse(2148, 1);
    wait_ov("midreset_ov_after", seen);
    chk("midreset_val", int'($signed(sample_out)), 1600);

    // DC convergence then a step that must saturate
    do_reset();
    for (int i = 0; i < 200; i++) block4(3072);
    repeat (4) @(negedge clk);
    chk("dc_settled", int'($signed(sample_out) <= 16 && $signed(sample_out) >= -16), 1);
    block4(0);
    wait_ov("step_ov", seen);
    chk("step_val", int'($signed(sample_out)), -32768);
    chk("step_clip", int'(clip), 1);

    // Randomized traffic with mute toggles and occasional stalls
    for (int i = 0; i < 300; i++) begin
      int v;
      if ($urandom_range(0, 7) == 0) mute_req = ~mute_req;
      case ($urandom_range(0, 9))
        0:       v = 0;
        1:       v = 4095;
        default: v = int'($urandom_range(0, 4095));
      endcase
      pulse(v, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      if ($urandom_range(0, 39) == 0) repeat (120) @(posedge clk);
    end
    mute_req = 1'b0;
    repeat (10) @(posedge clk);
    #2 mute = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_adc_conditioner.md
Name: audio_adc_conditioner

Overview:
Conditioning stage between the MCP3202 SPI ADC core and the HDMI audio sample path. It takes raw 12-bit unsigned ADC words and their data-valid level, then:
- edge-detects the valid level,
- decimates by boxcar averaging,
- removes DC offset with a leaky integrator,
- saturates to signed 16-bit.
A watchdog mutes the output when the ADC stops delivering samples. It runs in the 135 MHz ADC clock domain and replaces the raw shift-and-LPF feed into the HDMI sample word.

Parameters:
DECIM_LOG2, 2, log2 of samples averaged per output (legal 0..6).
DC_SHIFT, 10, leaky-integrator time constant: dc moves 2^-DC_SHIFT of the error per output (legal 1..15).
ENABLE_DC, 1, 1 = subtract DC estimate; 0 = bypass (dc treated as 0, integrator still updates).
TIMEOUT, 50000, clk cycles without an accepted sample before fault/mute (legal 2..2^20-1).

Ports:
clk  in  1  ADC-domain clock (135 MHz)
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  ADC data-valid level; may stay high many cycles
audio_sample  in  12  unsigned offset-binary ADC word, valid while sample_valid=1
mute  in  1  force sample_out to 0 (pipeline keeps running)
sample_out  out  16  signed conditioned sample, held between updates
out_valid  out  1  one-cycle pulse when sample_out updates
clip  out  1  one-cycle pulse coincident with out_valid when saturation occurred
adc_fault  out  1  high while watchdog expired

Behaviour:
- Reset (async assert, sync release): sv_q=0, acc=0, count=0, dc_acc=0, wd=0, FSM=IDLE. sample_out=0, out_valid=0, clip=0, adc_fault=0.
- Accept: sample_valid=1 && sv_q=0 (rising edge); sv_q <= sample_valid every cycle. A level held for N cycles is one sample. A rising edge in the first cycle after reset counts.
- Conversion: x = audio_sample - 2048, signed 12-bit, range -2048..2047.
- Accumulate:
  - acc (12+DECIM_LOG2 bits, signed) adds x on each accept; count increments modulo 2^DECIM_LOG2.
  - On the accept that wraps count to 0: avg16 = {acc_total[11+D:D], 4'b0}, where acc_total includes this x (arithmetic truncation toward -inf, x16).
  - Same cycle: acc <= 0, FSM IDLE->DCUPD.
  - Accumulation is independent of the FSM; accepts during DCUPD/SAT are never lost.
- FSM states (IDLE, DCUPD, SAT):
  - DCUPD (1 cycle): dc_acc (24-bit signed, 8 fractional bits) <= dc_acc + (({avg16,8'b0} - dc_acc) >>> DC_SHIFT). Subtraction uses dc = dc_acc[23:8] before the update.
  - SAT (1 cycle): y = avg16 - (ENABLE_DC ? dc : 0), 17-bit. Clamp to [-32768, 32767] and set clip_next if clamped. Register sample_out <= (mute|adc_fault) ? 0 : clamped. out_valid <= 1, clip <= clip_next, FSM -> IDLE.
- Latency: out_valid is high exactly 3 clk cycles after the cycle of the wrapping accept (accept = cycle t, DCUPD = t+1, SAT = t+2, out_valid/sample_out visible at t+3).
- Watchdog:
  - wd clears on every accept, otherwise increments (saturating).
  - When wd reaches TIMEOUT-1: adc_fault <= 1, sample_out <= 0, acc <= 0, count <= 0. No out_valid is generated.
  - adc_fault clears on the next accept; that sample starts a fresh decimation block. dc_acc is retained across faults.
- mute affects only the sample_out value; out_valid/clip cadence is unchanged.
- Simultaneous accept and watchdog expiry: accept wins (wd cleared, no fault).

Decomposition:
- Shared package audio_pkg: ADC_MIDSCALE=2048, S16_MAX/S16_MIN constants, typedef sample16_t (logic signed [15:0]), and the FSM state enum.
- One natural sub-module: audio_dc_blocker (the dc_acc register plus update/subtract/saturate, with a 2-cycle handshake from the FSM).
- Edge detect, accumulator and watchdog stay in the top.

Test Plan:
1. DECIM_LOG2=2, ENABLE_DC=0: four pulses of 2148 → sample_out=1600 and out_valid at t+3 after the 4th edge; clip=0.
2. DECIM_LOG2=2, ENABLE_DC=0: four samples of 0 → -32768, no clip. Four samples of 4095 → 32752, no clip.
3. sample_valid held high 10 cycles with value 2148, then low, repeated 4 times → exactly one out_valid, value 1600.
4. TIMEOUT=100, no edges → adc_fault=1 on cycle 99 after the last accept, sample_out=0. The next edge clears adc_fault; exactly 4 more edges are needed for the next out_valid.
5. DC_SHIFT=4, ENABLE_DC=1: constant 3072 (avg16=16384) for 200 outputs → |sample_out| ≤ 16 after settling. Then a step to 0 → first output clamps at -32768 with clip=1.
6. reset_n pulsed low asynchronously mid-DCUPD → all outputs 0 immediately, no out_valid after release, next block needs 4 fresh accepts. mute=1 → out_valid still pulses with sample_out=0.
